spi_tft_byte_tx: RTL and testbench
==================================

// Module: spi_tft_byte_tx
// PURPOSE
//   Serializes one command/data byte per request onto the 4-wire TFT SPI bus (SCLK, MOSI, CS_n, DC).
//   Sits directly downstream of the TFT screen-init sequencer and the pixel streamer.
//   Consumes {req, data, dc, end} and returns a one-cycle ack per byte.
//   Uses SPI mode 0 (CPOL=0, CPHA=0), MSB first.
// PARAMETERS
//   CLK_DIV   2   sys_clk cycles per SCLK half-period; must be >= 1 (elaboration error if 0)
//   CNT_W     8   half-period counter width; must satisfy 2**CNT_W > CLK_DIV
// PORTS
//   sys_clk       in   1  single clock; all logic is posedge
//   sys_rst_n     in   1  synchronous reset, active-low
//   send_req_i    in   1  byte request; held high by the source until ack
//   send_data_i   in   8  byte to send; sampled only when a request is accepted
//   send_dc_i     in   1  0 = command, 1 = data; sampled with send_data_i
//   send_end_i    in   1  level; close the transaction (raise CS_n) while idle
//   send_ack_o    out  1  one-cycle pulse: byte fully shifted out
//   busy_o        out  1  high in every state except S_IDLE
//   spi_sclk_o    out  1  SPI clock, idles low
//   spi_mosi_o    out  1  serial data, MSB first
//   spi_cs_n_o    out  1  chip select, active-low
//   spi_dc_o      out  1  TFT D/C line; holds the value latched with the current byte
// BEHAVIOUR
//   Reset (sync, sys_rst_n=0 at a posedge)
//     - State goes to S_IDLE.
//     - sclk=0, mosi=0, cs_n=1, dc=0, ack=0, busy=0; bit and half-period counters = 0.
//     - Reset mid-byte aborts the byte immediately; no ack is issued.
//   All outputs are registered except send_ack_o and busy_o, which decode the state.
//   States (one-hot): S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_ACK
//   S_IDLE
//     - If req=1: latch data into the shift register and dc; set cs_n=0, dc=send_dc_i,
//       mosi=data[7]; go to S_SETUP.
//     - Else if end=1: cs_n<=1.
//     - If req and end are both high, req wins; end is ignored.
//   S_SETUP: hold CLK_DIV cycles (CS-to-first-edge setup), sclk=0, then go to S_SHIFT.
//   S_SHIFT: 16 half-periods of CLK_DIV cycles each.
//     - At the end of each even half-period (0,2,..,14): sclk 0->1 (slave samples).
//     - At the end of each odd half-period: sclk 1->0, and mosi shifts to the next bit.
//     - After the 16th half-period (8th falling edge), sclk=0; go to S_HOLD.
//   S_HOLD: CLK_DIV cycles, cs_n stays low, mosi holds bit0; then go to S_ACK.
//   S_ACK: send_ack_o=1 for exactly one cycle, then S_IDLE. cs_n stays low.
//   No new request is sampled in the ack cycle. A source that still shows req=1 during ack
//   is therefore never double-accepted.
//   Latency: ack is high during cycle 18*CLK_DIV+1 after the posedge that accepted req.
//     - Back-to-back bytes: 18*CLK_DIV+2 cycles per byte.
//   Inputs changing mid-byte: data/dc changes and req dropping are ignored; the byte always
//   completes. end=1 while busy is ignored (not remembered); it acts only in S_IDLE.
//   CS_n deasserts one cycle after end=1 is seen in S_IDLE; it never toggles inside a byte.
// TESTING
//   1. CLK_DIV=2, req with data=8'hA5, dc=0 -> MOSI sampled on 8 SCLK rises = 1,0,1,0,0,1,0,1;
//      DC=0 throughout; ack after exactly 37 cycles; one pulse.
//   2. Source holds req high through the ack cycle, then drops it -> exactly one byte sent;
//      busy_o=0 in the cycle after ack.
//   3. 19-byte init sequence with end pulses between bytes -> each byte framed by CS_n low;
//      CS_n rises 1 cycle after end; DC matches per byte (8'h3A cmd dc=0, 8'h55 data dc=1).
//   4. req and end both high in idle -> byte starts, CS_n stays low; data=8'h00 gives MOSI=0
//      on all 8 rises.
//   5. Reset asserted at the 5th SCLK rise -> next cycle sclk=0, cs_n=1, no ack; a new req
//      then sends cleanly.
//   6. CLK_DIV=1, data=8'hFF, dc=1 -> SCLK period 2 cycles; ack at cycle 19; MOSI=1 on all rises.

Source files
------------

// File: rtl/spi_tft_byte_tx.sv
// rtl/spi_tft_byte_tx.sv - SPI mode-0 byte serializer for a 4-wire TFT bus
//
// Purpose:
//   Takes one command/data byte per request and shifts it out MSB first on
//   SCLK/MOSI. CS_n frames the transaction and DC carries the D/C flag latched
//   with the byte. A single-cycle ack marks the end of each byte. CS_n is only
//   released by send_end_i while idle, so several bytes can share one frame.
//
// Ports:
//   sys_clk      in   clock, all logic on posedge
//   sys_rst_n    in   synchronous reset, active-low
//   send_req_i   in   byte request, held until ack
//   send_data_i  in   byte to send (sampled on accept)
//   send_dc_i    in   0 = command, 1 = data (sampled on accept)
//   send_end_i   in   raise CS_n while idle
//   send_ack_o   out  one-cycle pulse after the byte has been shifted out
//   busy_o       out  high whenever not idle
//   spi_sclk_o   out  SPI clock, idles low
//   spi_mosi_o   out  serial data, MSB first
//   spi_cs_n_o   out  chip select, active-low
//   spi_dc_o     out  TFT D/C line

module spi_tft_byte_tx #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       send_req_i,
  input  logic [7:0] send_data_i,
  input  logic       send_dc_i,
  input  logic       send_end_i,
  output logic       send_ack_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  output logic       spi_dc_o
);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_SETUP = 5'b00010;
  localparam logic [4:0] S_SHIFT = 5'b00100;
  localparam logic [4:0] S_HOLD  = 5'b01000;
  localparam logic [4:0] S_ACK   = 5'b10000;

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_tft_byte_tx: CLK_DIV must be >= 1");
    end
    if ((2 ** CNT_W) <= CLK_DIV) begin : g_bad_cnt_w
      $error("spi_tft_byte_tx: CNT_W too narrow for CLK_DIV");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [4:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_half;
  // Bit 7 goes straight to MOSI on accept, so only bits 6..0 need storing.
  logic [6:0]       r_shift;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_dc;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A request takes priority over end, so the frame stays open.
          if (send_req_i) begin
            r_shift <= send_data_i[6:0];
            r_mosi  <= send_data_i[7];
            r_dc    <= send_dc_i;
            r_cs_n  <= 1'b0;
            r_cnt   <= '0;
            r_half  <= '0;
            r_state <= S_SETUP;
          end else if (send_end_i) begin
            r_cs_n <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_cnt_done) begin
            r_cnt  <= '0;
            r_half <= r_half + 4'd1;
            if (!r_half[0]) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              // The last falling edge leaves bit 0 on MOSI through the hold.
              if (r_half != 4'd15) begin
                r_mosi  <= r_shift[6];
                r_shift <= {r_shift[5:0], 1'b0};
              end else begin
                r_state <= S_HOLD;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          // No request is looked at here, so a source still holding req
          // during the ack cannot get the same byte accepted twice.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_sclk  <= 1'b0;
          r_cnt   <= '0;
          r_half  <= '0;
        end
      endcase
    end
  end

  assign send_ack_o = (r_state == S_ACK);
  assign busy_o     = (r_state != S_IDLE);
  assign spi_sclk_o = r_sclk;
  assign spi_mosi_o = r_mosi;
  assign spi_cs_n_o = r_cs_n;
  assign spi_dc_o   = r_dc;

endmodule

// File: tb/tb_spi_tft_byte_tx.sv
// tb/tb_spi_tft_byte_tx.sv - self-checking bench for spi_tft_byte_tx

module tb_spi_tft_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req2, req1;
  logic [7:0] data;
  logic       dc, en;

  logic ack2, busy2, sclk2, mosi2, cs2, dco2;
  logic ack1, busy1, sclk1, mosi1, cs1, dco1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_tft_byte_tx #(.CLK_DIV(2), .CNT_W(8)) u_div2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .send_req_i(req2), .send_data_i(data),
    .send_dc_i(dc), .send_end_i(en), .send_ack_o(ack2), .busy_o(busy2),
    .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_cs_n_o(cs2), .spi_dc_o(dco2)
  );

  spi_tft_byte_tx #(.CLK_DIV(1), .CNT_W(8)) u_div1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .send_req_i(req1), .send_data_i(data),
    .send_dc_i(dc), .send_end_i(en), .send_ack_o(ack1), .busy_o(busy1),
    .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_n_o(cs1), .spi_dc_o(dco1)
  );

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       end_with_req;
    logic       end_after;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic s, output logic m, output logic c,
                        output logic d, output logic a, output logic b);
    if (sel == 1) begin
      s = sclk1; m = mosi1; c = cs1; d = dco1; a = ack1; b = busy1;
    end else begin
      s = sclk2; m = mosi2; c = cs2; d = dco2; a = ack2; b = busy2;
    end
  endtask

  // Sends one byte, holding req through the ack cycle, and checks framing,
  // serial bits, latency and the single ack.
  task automatic run_byte(input string nm, input int sel, input logic [7:0] d,
                          input logic dcv, input logic env, input logic [7:0] exp_bits,
                          input int exp_lat, input int exp_first, input int exp_span);
    logic s, m, c, dd, a, b, prev_s;
    logic [7:0] cap;
    int lat, nrise, first_rise, last_rise, nack, dc_bad, cs_bad, busy_after;
    cap = 8'h00; lat = -1; nrise = 0; first_rise = -1; last_rise = -1;
    nack = 0; dc_bad = 0; cs_bad = 0; busy_after = 0;
    data = d; dc = dcv; en = env;
    if (sel == 1) req1 = 1'b1; else req2 = 1'b1;
    prev_s = 1'b0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      step();
      if (k == 3) begin
        data = ~d;
        dc   = ~dcv;
      end
      sample(sel, s, m, c, dd, a, b);
      if (s && !prev_s) begin
        cap = {cap[6:0], m};
        nrise++;
        if (first_rise < 0) first_rise = k;
        last_rise = k;
      end
      prev_s = s;
      if (dd !== dcv) dc_bad++;
      if (c !== 1'b0) cs_bad++;
      if (a) begin
        nack++;
        lat = k;
      end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        req1 = 1'b0; req2 = 1'b0; en = 1'b0;
      end
      sample(sel, s, m, c, dd, a, b);
      if (a) nack++;
      if (b) busy_after++;
    end
    chk({nm, " bits"}, int'(cap), int'(exp_bits));
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " rises"}, nrise, 8);
    chk({nm, " first_rise"}, first_rise, exp_first);
    chk({nm, " rise_span"}, last_rise - first_rise, exp_span);
    chk({nm, " ack_pulses"}, nack, 1);
    chk({nm, " dc_bad"}, dc_bad, 0);
    chk({nm, " cs_bad"}, cs_bad, 0);
    chk({nm, " busy_after"}, busy_after, 0);
  endtask

  initial begin
    logic s, prev_s;
    int nr, nack;

    rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; data = 8'h00; dc = 1'b0; en = 1'b0;
    step(); step(); step();
    chk("rst sclk2", int'(sclk2), 0);
    chk("rst mosi2", int'(mosi2), 0);
    chk("rst cs2", int'(cs2), 1);
    chk("rst dc2", int'(dco2), 0);
    chk("rst ack2", int'(ack2), 0);
    chk("rst busy2", int'(busy2), 0);
    chk("rst sclk1", int'(sclk1), 0);
    chk("rst mosi1", int'(mosi1), 0);
    chk("rst cs1", int'(cs1), 1);
    chk("rst dc1", int'(dco1), 0);
    chk("rst ack1", int'(ack1), 0);
    chk("rst busy1", int'(busy1), 0);
    rst_n = 1'b1;
    step();

    vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 1'b1, 8'h01});
    vecs.push_back('{8'h11, 1'b0, 1'b0, 1'b1, 8'h11});
    vecs.push_back('{8'h3A, 1'b0, 1'b0, 1'b0, 8'h3A});
    vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 8'h55});
    vecs.push_back('{8'h36, 1'b0, 1'b0, 1'b0, 8'h36});
    vecs.push_back('{8'h48, 1'b1, 1'b0, 1'b1, 8'h48});
    vecs.push_back('{8'h2A, 1'b0, 1'b0, 1'b0, 8'h2A});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'hEF, 1'b1, 1'b0, 1'b1, 8'hEF});
    vecs.push_back('{8'h2B, 1'b0, 1'b0, 1'b0, 8'h2B});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{8'h3F, 1'b1, 1'b0, 1'b1, 8'h3F});
    vecs.push_back('{8'h13, 1'b0, 1'b0, 1'b1, 8'h13});
    vecs.push_back('{8'h29, 1'b0, 1'b0, 1'b1, 8'h29});
    vecs.push_back('{8'h2C, 1'b0, 1'b0, 1'b1, 8'h2C});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 8'h00});

    foreach (vecs[i]) begin
      run_byte($sformatf("vec%0d", i), 2, vecs[i].data, vecs[i].dc, vecs[i].end_with_req,
               vecs[i].exp_bits, 37, 5, 28);
      if (vecs[i].end_after) begin
        chk($sformatf("vec%0d cs_before_end", i), int'(cs2), 0);
        en = 1'b1;
        step();
        chk($sformatf("vec%0d cs_rise", i), int'(cs2), 1);
        en = 1'b0;
        step();
      end else begin
        chk($sformatf("vec%0d cs_held", i), int'(cs2), 0);
      end
    end

    // Reset at the 5th SCLK rise aborts the byte without an ack.
    data = 8'hC3; dc = 1'b1; req2 = 1'b1;
    nr = 0; prev_s = 1'b0;
    for (int k = 0; k < 200 && nr < 5; k++) begin
      step();
      s = sclk2;
      if (s && !prev_s) nr++;
      prev_s = s;
    end
    chk("abort rise_count", nr, 5);
    rst_n = 1'b0; req2 = 1'b0;
    step();
    chk("abort sclk", int'(sclk2), 0);
    chk("abort cs", int'(cs2), 1);
    chk("abort busy", int'(busy2), 0);
    chk("abort mosi", int'(mosi2), 0);
    chk("abort dc", int'(dco2), 0);
    rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack2) nack++;
    end
    chk("abort no_ack", nack, 0);
    run_byte("after_abort", 2, 8'h96, 1'b0, 1'b0, 8'h96, 37, 5, 28);

    // Fastest divider: SCLK period of 2 cycles.
    run_byte("div1", 1, 8'hFF, 1'b1, 1'b0, 8'hFF, 19, 3, 14);
    run_byte("div1_b", 1, 8'h6C, 1'b0, 1'b0, 8'h6C, 19, 3, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
